// File: rtl/sdram_burst_writer_if.sv
// Avalon-MM burst write bus between sdram_burst_writer (master) and the SDRAM controller (slave).
interface sdram_burst_writer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 32
);
  logic                  master_waitrequest;
  logic [ADDR_W-1:0]     master_address;
  logic [DATA_W/8-1:0]   master_byteenable;
  logic                  master_write;
  logic [DATA_W-1:0]     master_writedata;
  logic [7:0]            master_burstcount;

  modport master (
    input  master_waitrequest,
    output master_address,
    output master_byteenable,
    output master_write,
    output master_writedata,
    output master_burstcount
  );

  modport slave (
    output master_waitrequest,
    input  master_address,
    input  master_byteenable,
    input  master_write,
    input  master_writedata,
    input  master_burstcount
  );
endinterface

// File: rtl/sdram_burst_writer.sv
// FIFO-buffered Avalon-MM burst write master: queues {addr,data} words and issues fixed-length
// bursts, or a partial burst on flush, toward the SDRAM controller.
module sdram_burst_writer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                write_en,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   addr,
  output logic                dev_idle,
  input  logic                flush,
  output logic                flush_done,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    fifo_usedw,
  sdram_burst_writer_if.master av
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WordW = ADDR_W + DATA_W;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // FIFO storage and pointers
  logic [WordW-1:0]  mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]  usedw_q;

  // Burst FSM state and registered bus outputs
  state_e            state_q;
  logic              write_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writedata_q;
  logic [7:0]        burst_q;
  logic [7:0]        beat_q;

  logic              flush_pending_q;
  logic              flush_done_q;
  logic              overflow_q;

  logic              full;
  logic              pop;
  logic              push;
  logic              ovf_event;
  logic              start_full;
  logic              start_part;
  logic [WordW-1:0]  head_word;
  logic [WordW-1:0]  next_word;

  always_comb begin
    full       = (usedw_q == CNT_W'(FIFO_DEPTH));
    pop        = write_q && !av.master_waitrequest;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push       = write_en && (!full || pop);
    ovf_event  = write_en && full && !pop;
    rd_ptr_nxt = rd_ptr_q + PtrW'(1);
    head_word  = mem[rd_ptr_q];
    next_word  = mem[rd_ptr_nxt];
    start_full = (state_q == StIdle) && (usedw_q >= CNT_W'(BURST_LEN));
    start_part = (state_q == StIdle) && !start_full && flush_pending_q && (usedw_q != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {addr, data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      if (push && !pop) begin
        usedw_q <= usedw_q + CNT_W'(1);
      end else if (pop && !push) begin
        usedw_q <= usedw_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_full || start_part) begin
            burst_q     <= start_full ? 8'(BURST_LEN) : 8'(usedw_q);
            address_q   <= head_word[WordW-1:DATA_W];
            writedata_q <= head_word[DATA_W-1:0];
            beat_q      <= '0;
            write_q     <= 1'b1;
            state_q     <= StBurst;
          end
        end
        StBurst: begin
          if (pop) begin
            if (beat_q == burst_q - 8'd1) begin
              write_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              // Burst length never exceeds occupancy at start, so the next word is valid.
              beat_q      <= beat_q + 8'd1;
              writedata_q <= next_word[DATA_W-1:0];
            end
          end
        end
        default: begin
          write_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (flush_pending_q && (state_q == StIdle) && (usedw_q == '0)) begin
        flush_pending_q <= 1'b0;
        flush_done_q    <= 1'b1;
      end
      if (flush) begin
        flush_pending_q <= 1'b1;
      end
      // A new overflow takes priority over a simultaneous clear.
      if (ovf_event) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign dev_idle   = (usedw_q < CNT_W'(FIFO_DEPTH));
  assign fifo_usedw = usedw_q;
  assign flush_done = flush_done_q;
  assign overflow   = overflow_q;

  assign av.master_address    = address_q;
  assign av.master_byteenable = '1;
  assign av.master_write      = write_q;
  assign av.master_writedata  = writedata_q;
  assign av.master_burstcount = burst_q;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench for sdram_burst_writer: bursts, waitrequest stalls, flush, overflow, reset.
module tb_sdram_burst_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_en;
  logic [15:0] data;
  logic [31:0] addr;
  logic        dev_idle;
  logic        flush;
  logic        flush_done;
  logic        overflow;
  logic        ovf_clr;
  logic [6:0]  fifo_usedw;

  sdram_burst_writer_if #(.DATA_W(16), .ADDR_W(32)) bus ();

  sdram_burst_writer #(
    .DATA_W(16), .ADDR_W(32), .BURST_LEN(16), .FIFO_DEPTH(64), .CNT_W(7)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .write_en   (write_en),
    .data       (data),
    .addr       (addr),
    .dev_idle   (dev_idle),
    .flush      (flush),
    .flush_done (flush_done),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .fifo_usedw (fifo_usedw),
    .av         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;

  logic [15:0] beat_data [$];
  logic [31:0] beat_addr [$];
  logic [7:0]  beat_bc   [$];
  int          beat_cyc  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    beat_data.delete();
    beat_addr.delete();
    beat_bc.delete();
    beat_cyc.delete();
    n_done = 0;
  endtask

  // Called at a negedge with inputs already set; logs the beat the coming posedge accepts.
  task automatic tick();
    #1;
    if (reset_n && bus.master_write && !bus.master_waitrequest) begin
      beat_data.push_back(bus.master_writedata);
      beat_addr.push_back(bus.master_address);
      beat_bc.push_back(bus.master_burstcount);
      beat_cyc.push_back(cyc);
    end
    if (flush_done) n_done++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_words(input int n, input logic [31:0] a0, input logic [15:0] d0);
    for (int i = 0; i < n; i++) begin
      write_en = 1'b1;
      addr     = a0 + 32'(2 * i);
      data     = d0 + 16'(i);
      tick();
    end
    write_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int c = 0; c < max_cyc && !(fifo_usedw == 0 && !bus.master_write); c++) tick();
  endtask

  int stalls;

  initial begin
    reset_n  = 1'b0;
    write_en = 1'b0;
    data     = '0;
    addr     = '0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
    bus.master_waitrequest = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_write", bus.master_write, 0);
    check("rst_address", bus.master_address, 0);
    check("rst_burstcount", bus.master_burstcount, 0);
    check("rst_writedata", bus.master_writedata, 0);
    check("rst_usedw", fifo_usedw, 0);
    check("rst_dev_idle", dev_idle, 1);
    check("rst_overflow", overflow, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_byteenable", bus.master_byteenable, 2'b11);
    reset_n = 1'b1;
    tick();

    // 1: single 16-beat burst, zero waitstates
    clear_log();
    push_words(16, 32'h100, 16'd0);
    check("t1_usedw16", fifo_usedw, 16);
    check("t1_write_not_yet", bus.master_write, 0);
    tick();
    check("t1_write_first", bus.master_write, 1);
    check("t1_address", bus.master_address, 32'h100);
    check("t1_burstcount", bus.master_burstcount, 16);
    check("t1_wd0", bus.master_writedata, 0);
    drain(60);
    check("t1_drained_usedw", fifo_usedw, 0);
    check("t1_nbeats", beat_data.size(), 16);
    if (beat_data.size() == 16) begin
      for (int i = 0; i < 16; i++) check($sformatf("t1_data%0d", i), beat_data[i], i);
      check("t1_addr_last", beat_addr[15], 32'h100);
      check("t1_span", beat_cyc[15] - beat_cyc[0], 15);
    end

    // 2: waitrequest held for 3 cycles at beat 5
    clear_log();
    stalls = 0;
    push_words(16, 32'h200, 16'h20);
    for (int c = 0; c < 80 && beat_data.size() < 16; c++) begin
      if (bus.master_write && beat_data.size() == 5 && stalls < 3) begin
        bus.master_waitrequest = 1'b1;
        stalls++;
        check($sformatf("t2_frozen_wd%0d", stalls), bus.master_writedata, 16'h25);
        check($sformatf("t2_frozen_addr%0d", stalls), bus.master_address, 32'h200);
      end else begin
        bus.master_waitrequest = 1'b0;
      end
      tick();
    end
    bus.master_waitrequest = 1'b0;
    drain(20);
    check("t2_nbeats", beat_data.size(), 16);
    if (beat_data.size() == 16) begin
      for (int i = 0; i < 16; i++) check($sformatf("t2_data%0d", i), beat_data[i], 16'h20 + i);
      check("t2_span", beat_cyc[15] - beat_cyc[0], 18);
    end
    check("t2_usedw", fifo_usedw, 0);

    // 3: partial burst on flush
    clear_log();
    push_words(5, 32'h300, 16'hA0);
    tick();
    check("t3_no_burst_yet", bus.master_write, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("t3_nbeats", beat_data.size(), 5);
    if (beat_data.size() == 5) begin
      check("t3_bc", beat_bc[0], 5);
      check("t3_addr", beat_addr[0], 32'h300);
      for (int i = 0; i < 5; i++) check($sformatf("t3_data%0d", i), beat_data[i], 16'hA0 + i);
    end
    check("t3_flush_done_count", n_done, 1);
    check("t3_usedw", fifo_usedw, 0);

    // 4: overflow with the slave stalled
    clear_log();
    bus.master_waitrequest = 1'b1;
    push_words(64, 32'h2000, 16'd0);
    check("t4_usedw_full", fifo_usedw, 64);
    check("t4_dev_idle_full", dev_idle, 0);
    check("t4_no_ovf_yet", overflow, 0);
    push_words(1, 32'hFFFF, 16'hDEAD);
    check("t4_usedw_after_drop", fifo_usedw, 64);
    check("t4_overflow", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_cleared", overflow, 0);
    ovf_clr  = 1'b1;
    write_en = 1'b1;
    data     = 16'hBEEF;
    tick();
    ovf_clr  = 1'b0;
    write_en = 1'b0;
    check("t4_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_cleared2", overflow, 0);
    bus.master_waitrequest = 1'b0;
    push_words(1, 32'h3000, 16'h1FF);
    check("t4_push_pop_full_usedw", fifo_usedw, 64);
    check("t4_push_pop_no_ovf", overflow, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 200 && n_done == 0; c++) tick();
    check("t4_flush_done", n_done, 1);
    check("t4_nbeats", beat_data.size(), 65);
    if (beat_data.size() == 65) begin
      for (int i = 0; i < 64; i++) check($sformatf("t4_data%0d", i), beat_data[i], i);
      check("t4_data_last", beat_data[64], 16'h1FF);
      check("t4_addr0", beat_addr[0], 32'h2000);
      check("t4_bc_last", beat_bc[64], 1);
    end
    check("t4_usedw_end", fifo_usedw, 0);

    // 5: continuous 1 word/cycle stream -> back-to-back bursts
    clear_log();
    push_words(64, 32'h1000, 16'h300);
    drain(100);
    check("t5_nbeats", beat_data.size(), 64);
    check("t5_overflow", overflow, 0);
    if (beat_data.size() == 64) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t5_addr_b%0d", k), beat_addr[16 * k], 32'h1000 + 32 * k);
        check($sformatf("t5_addr_end_b%0d", k), beat_addr[16 * k + 15], 32'h1000 + 32 * k);
        check($sformatf("t5_bc_b%0d", k), beat_bc[16 * k], 16);
      end
      for (int i = 0; i < 64; i++) check($sformatf("t5_data%0d", i), beat_data[i], 16'h300 + i);
      check("t5_idle_gap", beat_cyc[16] - beat_cyc[15], 2);
    end

    // 6: reset during beat 7
    clear_log();
    push_words(16, 32'h400, 16'h40);
    for (int c = 0; c < 40 && beat_data.size() < 7; c++) tick();
    check("t6_in_burst", bus.master_write, 1);
    reset_n = 1'b0;
    #1;
    check("t6_write_async", bus.master_write, 0);
    check("t6_usedw_async", fifo_usedw, 0);
    check("t6_dev_idle", dev_idle, 1);
    check("t6_address", bus.master_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("t6_idle_write", bus.master_write, 0);
    check("t6_idle_usedw", fifo_usedw, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_done_not_yet", flush_done, 0);
    tick();
    check("t6_done_pulse", flush_done, 1);
    tick();
    check("t6_done_single", flush_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_burst_writer.md
# sdram_burst_writer

Parametrised FIFO-buffered Avalon-MM burst write master between the ADC/channel data path and the SDRAM controller slave port. It accepts {address, data} words on a simple valid/ready-style input and queues them in an internal show-ahead FIFO. It issues fixed-length bursts when enough words are queued, and a partial burst on an explicit flush request. It generalises the earlier fixed 16-bit/16-beat writer with configurable width, depth and burst length, partial-burst flush, and overflow reporting.

## Interface
- DATA_W, 16, data width in bits; multiple of 8.
- ADDR_W, 32, Avalon byte address width.
- BURST_LEN, 16, full burst length in beats; 2..128.
- FIFO_DEPTH, 64, FIFO words; power of 2, ≥ 2*BURST_LEN.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the usedw counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- write_en  in  1  push {addr,data} into the FIFO this cycle.
- data  in  DATA_W  write data.
- addr  in  ADDR_W  byte address of this word.
- dev_idle  out  1  high when FIFO can accept a word (usedw < FIFO_DEPTH).
- flush  in  1  one-cycle request to drain all queued words, including a partial burst.
- flush_done  out  1  one-cycle pulse when a requested flush has completed.
- overflow  out  1  sticky; set when write_en arrives while full.
- ovf_clr  in  1  clears overflow.
- fifo_usedw  out  CNT_W  current FIFO occupancy.
- master_waitrequest  in  1  Avalon waitrequest.
- master_address  out  ADDR_W  burst start address.
- master_byteenable  out  DATA_W/8  constant all ones.
- master_write  out  1  Avalon write.
- master_writedata  out  DATA_W  current beat data (FIFO head).
- master_burstcount  out  8  beats in the current burst.

## Operation
- FIFO: circular RAM, show-ahead head word, occupancy counter fifo_usedw (0..FIFO_DEPTH).
  - Push when write_en && usedw<FIFO_DEPTH.
  - Pop when a beat is accepted (master_write && !master_waitrequest).
  - Simultaneous push and pop: usedw unchanged.
  - Push while full: word dropped, overflow←1.
  - ovf_clr and a simultaneous overflow event in the same cycle: the set wins.
- Flush: flush sets flush_pending. flush_pending clears, and flush_done pulses, in the cycle after the FIFO is empty with the FSM in IDLE. flush while empty and IDLE: flush_done pulses the next cycle.
- FSM states:
  - IDLE: master_write=0.
    - If usedw≥BURST_LEN: latch burstcount=BURST_LEN, go to BURST.
    - Else if flush_pending && usedw>0: latch burstcount=usedw, go to BURST.
    - On entry to BURST, latch master_address = head addr.
  - BURST: master_write=1; writedata=head data; beat counter increments per accepted beat. When the final beat (count==burstcount-1) is accepted, return to IDLE.
- Address handling: only the first word's address is used per burst. Addresses of beats 2..N are discarded; the producer guarantees contiguity.
- master_address and master_burstcount are held constant for the whole burst.
- Words pushed during a burst never extend the current burst.

## Timing
- Reset (asynchronous, immediate): FSM=IDLE; FIFO emptied; usedw=0; master_write=0; master_address=0; master_burstcount=0; master_writedata=0; overflow=0; flush_pending=0; flush_done=0; dev_idle=1.
- Reset mid-burst: master_write drops asynchronously; queued data is lost.
- Word pushed at edge N is visible in usedw and eligible for a burst at edge N+1. Earliest master_write is at edge N+2 after the BURST_LEN-th push.
- Waitrequest high: all master outputs are held and nothing is popped.
- Zero-waitstate burst: exactly burstcount consecutive write cycles, then at least one IDLE cycle before the next burst.
- dev_idle is combinational from usedw. A push and a pop at full in the same cycle: the push is accepted.
- writedata changes only on the cycle after an accepted beat.

## Test plan
- Push 16 words (addr 0x100, data 0..15), waitrequest=0 → one burst, address 0x100, burstcount 16, data 0..15 on 16 consecutive cycles, usedw returns to 0.
- Same as above with waitrequest high for 3 cycles at beat 5 → outputs frozen for 3 cycles, beat 5 data repeated, no loss or duplication in accepted beats.
- Push 5 words, assert flush → one burst with burstcount 5, then flush_done pulses once, usedw=0.
- Push 65 words with waitrequest=1 (FIFO_DEPTH=64) → usedw=64, dev_idle=0, overflow=1. After ovf_clr, overflow=0.
- Continuous push at 1 word/cycle with waitrequest=0 → back-to-back 16-beat bursts with addresses taken from word 0, 16, 32…, and no overflow.
- Assert reset_n low during beat 7 of a burst → master_write=0 immediately; after release, usedw=0 and FSM is in IDLE.
